awb_gain_stats: RTL and testbench

Parametrised gray-world auto-white-balance engine for the ISP raw path. It accumulates per-channel Bayer statistics over one frame of raw pixels. At end of frame it computes the red and blue gains relative to green with a shared serial divider, and publishes registered R/G/B gains to the downstream white-balance multiplier.

---
 rtl/awb_gain_stats.sv | 220 ++++++++++++++++++++++
 tb/tb_awb_gain_stats.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/awb_gain_stats.sv
// Gray-world auto-white-balance engine: per-channel Bayer statistics plus shared serial divider for R/B gains.
// Optional clip exclusion is enabled by defining AWB_CLIP_EXCLUDE_EN.
module awb_gain_stats #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned FRAC_W    = 4,
  parameter int unsigned BAYER     = 0,
  parameter int unsigned SAT_LEVEL = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              sof,
  input  logic              eol,
  input  logic              eof,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_g,
  output logic [GAIN_W-1:0] gain_b,
  output logic              gain_valid,
  output logic              busy
);

  localparam int unsigned       BIT_W    = $clog2(ACC_W + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(ACC_W);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << FRAC_W);
  localparam logic [1:0]        PHASE    = 2'(BAYER);
  localparam logic [DATA_W-1:0] SAT_TH   = DATA_W'(SAT_LEVEL);
  localparam logic [ACC_W-1:0]  GAIN_MAX = {{(ACC_W-GAIN_W){1'b0}}, {GAIN_W{1'b1}}};
`ifdef AWB_CLIP_EXCLUDE_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_UPDATE} state_t;

  state_t r_state, w_next;

  logic [ACC_W-1:0]  r_sum_r, r_sum_g, r_sum_b;
  logic [CNT_W-1:0]  r_cnt_r, r_cnt_g, r_cnt_b;
  logic              r_row, r_col;
  logic [ACC_W-1:0]  r_rem, r_quo, r_dvs;
  logic              r_dz;
  logic [BIT_W-1:0]  r_bit;
  logic [2:0]        r_idx;
  logic [ACC_W-1:0]  r_m_r, r_m_g, r_m_b, r_q_r, r_q_b;
  logic [GAIN_W-1:0] r_gain_r, r_gain_g, r_gain_b;
  logic              r_gain_valid;

  logic              w_acc, w_clear, w_row, w_col, w_keep;
  logic              w_hit_r, w_hit_g, w_hit_b;
  logic [1:0]        w_ch;
  logic [ACC_W-1:0]  w_bs_r, w_bs_g, w_bs_b;
  logic [CNT_W-1:0]  w_bc_r, w_bc_g, w_bc_b;
  logic [ACC_W-1:0]  w_dvd, w_dvs, w_diff, w_qres;
  logic [ACC_W:0]    w_trial;
  logic              w_ge;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-DATA_W){1'b0}}, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [ACC_W-1:0] q);
    return (q > GAIN_MAX) ? '1 : q[GAIN_W-1:0];
  endfunction

  // Parity of the current pixel: a sof pixel is always at row 0, column 0.
  always_comb begin
    w_row   = sof ? 1'b0 : r_row;
    w_col   = sof ? 1'b0 : r_col;
    w_ch    = {w_row, w_col} ^ PHASE;
    w_keep  = !(CLIP_EN && (din >= SAT_TH));
    w_hit_r = w_keep && (w_ch == 2'd0);
    w_hit_g = w_keep && ((w_ch == 2'd1) || (w_ch == 2'd2));
    w_hit_b = w_keep && (w_ch == 2'd3);
    w_acc   = din_valid && (((r_state == S_IDLE) && sof) || (r_state == S_ACCUM));
    w_clear = w_acc && sof;
    w_bs_r  = w_clear ? '0 : r_sum_r;
    w_bs_g  = w_clear ? '0 : r_sum_g;
    w_bs_b  = w_clear ? '0 : r_sum_b;
    w_bc_r  = w_clear ? '0 : r_cnt_r;
    w_bc_g  = w_clear ? '0 : r_cnt_g;
    w_bc_b  = w_clear ? '0 : r_cnt_b;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (din_valid && sof) w_next = eof ? S_DIVIDE : S_ACCUM;
      S_ACCUM:  if (din_valid && eof) w_next = S_DIVIDE;
      S_DIVIDE: if ((r_bit == '0) && (r_idx == 3'd5)) w_next = S_UPDATE;
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_DIVIDE) || (r_state == S_UPDATE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= 1'b0;
      r_col   <= 1'b0;
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else begin
      if (din_valid) begin
        r_col <= eol ? 1'b0 : ~w_col;
        r_row <= eol ? ~w_row : w_row;
      end
      if (w_acc) begin
        r_sum_r <= w_hit_r ? sat_add(w_bs_r, din) : w_bs_r;
        r_sum_g <= w_hit_g ? sat_add(w_bs_g, din) : w_bs_g;
        r_sum_b <= w_hit_b ? sat_add(w_bs_b, din) : w_bs_b;
        r_cnt_r <= w_hit_r ? sat_inc(w_bc_r) : w_bc_r;
        r_cnt_g <= w_hit_g ? sat_inc(w_bc_g) : w_bc_g;
        r_cnt_b <= w_hit_b ? sat_inc(w_bc_b) : w_bc_b;
      end
    end
  end

  // Operand mux per division slot; slots 3/4 reuse means captured by earlier slots.
  always_comb begin
    w_dvd = '0;
    w_dvs = '0;
    case (r_idx)
      3'd0: begin w_dvd = r_sum_r; w_dvs = {{(ACC_W-CNT_W){1'b0}}, r_cnt_r}; end
      3'd1: begin w_dvd = r_sum_g; w_dvs = {{(ACC_W-CNT_W){1'b0}}, r_cnt_g}; end
      3'd2: begin w_dvd = r_sum_b; w_dvs = {{(ACC_W-CNT_W){1'b0}}, r_cnt_b}; end
      3'd3: begin w_dvd = r_m_g << FRAC_W; w_dvs = r_m_r; end
      3'd4: begin w_dvd = r_m_g << FRAC_W; w_dvs = r_m_b; end
      default: ;
    endcase
    w_trial = {r_rem, r_quo[ACC_W-1]};
    w_ge    = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial[ACC_W-1:0] - r_dvs;
    w_qres  = r_dz ? '0 : r_quo;
  end

  // Each load cycle also retires the quotient of the previous slot, so slot 5 is retire-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_dz  <= 1'b0;
      r_bit <= '0;
      r_idx <= '0;
      r_m_r <= '0;
      r_m_g <= '0;
      r_m_b <= '0;
      r_q_r <= '0;
      r_q_b <= '0;
    end else if (r_state == S_DIVIDE) begin
      if (r_bit == '0) begin
        case (r_idx)
          3'd1: r_m_r <= w_qres;
          3'd2: r_m_g <= w_qres;
          3'd3: r_m_b <= w_qres;
          3'd4: r_q_r <= w_qres;
          3'd5: r_q_b <= w_qres;
          default: ;
        endcase
        r_rem <= '0;
        r_quo <= w_dvd;
        r_dvs <= w_dvs;
        r_dz  <= (w_dvs == '0);
        r_idx <= r_idx + 3'd1;
        r_bit <= BIT_W'(1);
      end else begin
        r_rem <= w_ge ? w_diff : w_trial[ACC_W-1:0];
        r_quo <= {r_quo[ACC_W-2:0], w_ge};
        r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
      end
    end else begin
      r_bit <= '0;
      r_idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain_r     <= UNITY;
      r_gain_g     <= UNITY;
      r_gain_b     <= UNITY;
      r_gain_valid <= 1'b0;
    end else begin
      r_gain_valid <= 1'b0;
      if (r_state == S_UPDATE) begin
        r_gain_g     <= UNITY;
        r_gain_r     <= ((r_m_r == '0) || (r_m_g == '0)) ? UNITY : clamp_gain(r_q_r);
        r_gain_b     <= ((r_m_b == '0) || (r_m_g == '0)) ? UNITY : clamp_gain(r_q_b);
        r_gain_valid <= 1'b1;
      end
    end
  end

  assign gain_r     = r_gain_r;
  assign gain_g     = r_gain_g;
  assign gain_b     = r_gain_b;
  assign gain_valid = r_gain_valid;

endmodule

// File: tb/tb_awb_gain_stats.sv
// Self-checking bench for awb_gain_stats: four instances (BAYER 0..3) share stimulus, checked against a frame-level model.
module tb_awb_gain_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        din_valid, sof, eol, eof;
  logic [7:0]  gr[4], gg[4], gb[4];
  logic        gv[4], bsy[4];

  int total = 0;
  int bad   = 0;
  int fpix[8][8];
  int fw, fh;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    awb_gain_stats #(.BAYER(k)) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .sof(sof), .eol(eol), .eof(eof),
      .gain_r(gr[k]), .gain_g(gg[k]), .gain_b(gb[k]),
      .gain_valid(gv[k]), .busy(bsy[k])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain_rule(input longint m, input longint mg);
    longint q;
    if (m == 0 || mg == 0) return 16;
    q = (mg * 16) / m;
    return (q > 255) ? 255 : int'(q);
  endfunction

  // Gray-world model straight from the CFA layout of the frame buffer.
  task automatic model(input int bayer, output int er, output int eb);
    longint s[3];
    longint c[3];
    longint m[3];
    for (int i = 0; i < 3; i++) begin s[i] = 0; c[i] = 0; end
    for (int r = 0; r < fh; r++)
      for (int x = 0; x < fw; x++) begin
        int ch, idx;
        ch  = (((r % 2) << 1) | (x % 2)) ^ bayer;
        idx = (ch == 0) ? 0 : (ch == 3) ? 2 : 1;
`ifdef AWB_CLIP_EXCLUDE_EN
        if (fpix[r][x] >= 4095) continue;
`endif
        s[idx] += fpix[r][x];
        c[idx] += 1;
      end
    for (int i = 0; i < 3; i++) m[i] = (c[i] != 0) ? s[i] / c[i] : 0;
    er = gain_rule(m[0], m[1]);
    eb = gain_rule(m[2], m[1]);
  endtask

  task automatic fill_rgb(input int w, input int h, input int rv, input int gval, input int bv);
    fw = w;
    fh = h;
    for (int r = 0; r < h; r++)
      for (int x = 0; x < w; x++) begin
        int ch;
        ch = ((r % 2) << 1) | (x % 2);
        fpix[r][x] = (ch == 0) ? rv : (ch == 3) ? bv : gval;
      end
  endtask

  task automatic idle_inputs();
    din_valid = 1'b0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
  endtask

  task automatic drive_frame(input bit bubbles);
    for (int r = 0; r < fh; r++)
      for (int x = 0; x < fw; x++) begin
        if (bubbles && $urandom_range(0, 3) == 0) begin
          din_valid = 1'b0; sof = 1'b1; eol = 1'b1; eof = 1'b1; din = 12'($urandom);
          @(posedge clk); #1;
        end
        din_valid = 1'b1;
        din = 12'(fpix[r][x]);
        sof = (r == 0 && x == 0);
        eol = (x == fw - 1);
        eof = (r == fh - 1 && x == fw - 1);
        @(posedge clk); #1;
      end
    idle_inputs();
  endtask

  task automatic wait_gains(output int n);
    n = 0;
    while (!gv[0] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_gv(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (gv[0]) cnt++;
    end
  endtask

  task automatic run_frame(input string tag, input bit bubbles);
    int n, er, eb;
    drive_frame(bubbles);
    check_val({tag, "_busy"}, 64'(bsy[0]), 64'd1);
    wait_gains(n);
    check_val({tag, "_lat"}, 64'(n), 64'd207);
    for (int k = 0; k < 4; k++) begin
      model(k, er, eb);
      check_val($sformatf("%s_gv%0d", tag, k), 64'(gv[k]), 64'd1);
      check_val($sformatf("%s_gr%0d", tag, k), 64'(gr[k]), 64'(er));
      check_val($sformatf("%s_gg%0d", tag, k), 64'(gg[k]), 64'd16);
      check_val($sformatf("%s_gb%0d", tag, k), 64'(gb[k]), 64'(eb));
    end
    check_val({tag, "_busy_fall"}, 64'(bsy[0]), 64'd0);
  endtask

  initial begin
    int n, cnt;
    rst = 1'b1;
    din = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("rst_gr", 64'(gr[0]), 64'd16);
    check_val("rst_gg", 64'(gg[0]), 64'd16);
    check_val("rst_gb", 64'(gb[0]), 64'd16);
    check_val("rst_gv", 64'(gv[0]), 64'd0);
    check_val("rst_busy", 64'(bsy[0]), 64'd0);

    fill_rgb(4, 4, 100, 200, 50);
    run_frame("gray", 1'b0);
    check_val("gray_gr", 64'(gr[0]), 64'd32);
    check_val("gray_gb", 64'(gb[0]), 64'd64);
    @(posedge clk); #1;
    check_val("gv_pulse", 64'(gv[0]), 64'd0);

    fill_rgb(4, 4, 1000, 1000, 1000);
    run_frame("flat", 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("flat_r%0d", k), 64'(gr[k]), 64'd16);
      check_val($sformatf("flat_b%0d", k), 64'(gb[k]), 64'd16);
    end

    fill_rgb(4, 4, 800, 800, 0);
    run_frame("bzero", 1'b0);
    check_val("bzero_gb", 64'(gb[0]), 64'd16);
    check_val("bzero_gr", 64'(gr[0]), 64'd16);

    fill_rgb(4, 4, 10, 4000, 4000);
    run_frame("clamp", 1'b0);
    check_val("clamp_gr", 64'(gr[0]), 64'd255);

    // Second frame arrives while busy and must leave no trace.
    fill_rgb(4, 4, 100, 200, 50);
    drive_frame(1'b0);
    repeat (20) @(posedge clk);
    #0;
    fill_rgb(4, 4, 500, 500, 500);
    drive_frame(1'b0);
    wait_gains(n);
    check_val("skip_lat", 64'(n + 36), 64'd207);
    check_val("skip_gr", 64'(gr[0]), 64'd32);
    check_val("skip_gb", 64'(gb[0]), 64'd64);
    count_gv(300, cnt);
    check_val("skip_nogv", 64'(cnt), 64'd0);
    check_val("skip_gr_hold", 64'(gr[0]), 64'd32);

    fill_rgb(4, 4, 10, 4000, 4000);
    drive_frame(1'b0);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_val("abort_gr", 64'(gr[0]), 64'd16);
    check_val("abort_gb", 64'(gb[0]), 64'd16);
    check_val("abort_busy", 64'(bsy[0]), 64'd0);
    count_gv(250, cnt);
    check_val("abort_nogv", 64'(cnt), 64'd0);

    fw = 1; fh = 1; fpix[0][0] = 700;
    run_frame("onepix", 1'b0);
    check_val("onepix_gr", 64'(gr[0]), 64'd16);
    check_val("onepix_gb", 64'(gb[0]), 64'd16);

    fill_rgb(4, 4, 300, 300, 300);
    fpix[0][0] = 4095;
    fpix[0][2] = 4095;
    run_frame("clip", 1'b0);
`ifdef AWB_CLIP_EXCLUDE_EN
    check_val("clip_gr", 64'(gr[0]), 64'd16);
`else
    check_val("clip_gr", 64'(gr[0]), 64'd2);
`endif

    for (int t = 0; t < 8; t++) begin
      fw = $urandom_range(1, 8);
      fh = $urandom_range(1, 8);
      for (int r = 0; r < fh; r++)
        for (int x = 0; x < fw; x++)
          fpix[r][x] = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095));
      repeat (2) begin
        din_valid = 1'b1; sof = 1'b0; eof = 1'b1; eol = 1'($urandom); din = 12'($urandom);
        @(posedge clk); #1;
      end
      idle_inputs();
      run_frame($sformatf("rnd%0d", t), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
